// File: rtl/shifter.sv
// -----------------------------------------------------------------------------
// shifter
//   Single-cycle 16-bit logical barrel shifter with a registered result.
//   Four mux stages shift by 1, 2, 4 and 8. Each stage is enabled by the
//   matching bit of shift_amount and picks the left- or right-shifted tap
//   according to `left`. Vacated bits are always zero-filled.
//
// Ports
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous active-low reset, clears r to 0
//   shift_string in  16   operand
//   shift_amount in   4   shift distance 0..15
//   left         in   1   1 = shift left, 0 = shift right
//   r            out 16   registered result, one clock of latency
// -----------------------------------------------------------------------------
module shifter (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] shift_string,
   input  logic [3:0]  shift_amount,
   input  logic        left,
   output logic [15:0] r
);

   // w_stage[0] is the operand; w_stage[k+1] is the output of stage k.
   logic [4:0][15:0] w_stage;

   assign w_stage[0] = shift_string;

   for (genvar k = 0; k < 4; k++) begin : g_stage
      localparam int SH = 1 << k;
      logic [15:0] w_lft;
      logic [15:0] w_rgt;
      assign w_lft = w_stage[k] << SH;
      assign w_rgt = w_stage[k] >> SH;
      assign w_stage[k+1] = shift_amount[k] ? (left ? w_lft : w_rgt)
                                            : w_stage[k];
   end

   always_ff @(posedge clk) begin
      if (!reset) r <= '0;
      else        r <= w_stage[4];
   end

endmodule

// File: tb/tb_shifter.sv
module tb_shifter;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] shift_string;
   logic [3:0]  shift_amount;
   logic        left;
   logic [15:0] r;

   int n_vec = 0;
   int n_err = 0;

   shifter dut (
      .clk          (clk),
      .reset        (reset),
      .shift_string (shift_string),
      .shift_amount (shift_amount),
      .left         (left),
      .r            (r)
   );

   always #5 clk = ~clk;

   // Bit-by-bit reference: output bit i takes input bit i-a (left) or i+a (right).
   function automatic logic [15:0] ref_shift(input logic [15:0] s,
                                             input logic [3:0] a,
                                             input logic l);
      logic [15:0] o;
      int amt;
      o   = '0;
      amt = int'(a);
      for (int i = 0; i < 16; i++) begin
         if (l) begin
            if (i - amt >= 0) o[i] = s[i - amt];
         end else begin
            if (i + amt <= 15) o[i] = s[i + amt];
         end
      end
      return o;
   endfunction

   // Drive at the falling edge, then sample 1 ns after the next rising edge.
   task automatic drive_and_clock(input logic [15:0] s, input logic [3:0] a,
                                  input logic l);
      @(negedge clk);
      shift_string = s;
      shift_amount = a;
      left         = l;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      drive_and_clock(16'hFFFF, 4'd3, 1'b1);
      @(posedge clk); #1;
      n_vec++;
      if (r !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_hold: r=%h expected=%h", r, 16'h0000);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (r !== 16'hFFF8) begin
         n_err++;
         $display("FAIL reset_release: r=%h expected=%h", r, 16'hFFF8);
      end
   endtask

   typedef struct {
      logic [15:0] s;
      logic [3:0]  a;
      logic        l;
      logic [15:0] exp;
   } vec_t;

   task automatic test_directed;
      vec_t v[12];
      v[0]  = '{16'h0001, 4'd1,  1'b1, 16'h0002};
      v[1]  = '{16'h2222, 4'd1,  1'b0, 16'h1111};
      v[2]  = '{16'h8000, 4'd1,  1'b1, 16'h0000};
      v[3]  = '{16'h0004, 4'd3,  1'b0, 16'h0000};
      v[4]  = '{16'h2C8B, 4'd5,  1'b1, 16'h9160};
      v[5]  = '{16'hAAAA, 4'd5,  1'b0, 16'h0555};
      v[6]  = '{16'h1234, 4'd0,  1'b1, 16'h1234};
      v[7]  = '{16'h1234, 4'd0,  1'b0, 16'h1234};
      v[8]  = '{16'h0001, 4'd15, 1'b1, 16'h8000};
      v[9]  = '{16'h8000, 4'd15, 1'b0, 16'h0001};
      v[10] = '{16'hFFFF, 4'd8,  1'b0, 16'h00FF};
      v[11] = '{16'hFFFF, 4'd15, 1'b1, 16'h8000};
      foreach (v[i]) begin
         drive_and_clock(v[i].s, v[i].a, v[i].l);
         n_vec++;
         if (r !== v[i].exp) begin
            n_err++;
            $display("FAIL directed[%0d]: s=%h a=%0d l=%b r=%h expected=%h",
                     i, v[i].s, v[i].a, v[i].l, r, v[i].exp);
         end
      end
   endtask

   task automatic test_hold_between_edges;
      drive_and_clock(16'h00F0, 4'd4, 1'b1);
      // Inputs change mid-cycle; r must keep the value captured at the edge.
      shift_string = 16'hFFFF;
      shift_amount = 4'd0;
      left         = 1'b0;
      #2;
      n_vec++;
      if (r !== 16'h0F00) begin
         n_err++;
         $display("FAIL hold_between_edges: r=%h expected=%h", r, 16'h0F00);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] s;
      logic [3:0]  a;
      logic        l;
      for (int i = 0; i < 8; i++) begin
         s = 16'h1357 * 16'(i + 1) ^ 16'hA5C3;
         a = 4'(i * 3 + 1);
         l = i[0];
         drive_and_clock(s, a, l);
         n_vec++;
         if (r !== ref_shift(s, a, l)) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: r=%h expected=%h",
                     i, r, ref_shift(s, a, l));
         end
      end
   endtask

   task automatic test_sweep;
      logic [15:0] s;
      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < 16; a++) begin
            s = 16'($urandom);
            drive_and_clock(s, 4'(a), d[0]);
            n_vec++;
            if (r !== ref_shift(s, 4'(a), d[0])) begin
               n_err++;
               $display("FAIL sweep: s=%h a=%0d l=%0d r=%h expected=%h",
                        s, a, d, r, ref_shift(s, 4'(a), d[0]));
            end
         end
      end
   endtask

   task automatic test_reset_mid_op;
      drive_and_clock(16'h0F0F, 4'd2, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (r !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_mid_op: r=%h expected=%h", r, 16'h0000);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (r !== 16'h3C3C) begin
         n_err++;
         $display("FAIL reset_mid_op_release: r=%h expected=%h", r, 16'h3C3C);
      end
   endtask

   initial begin
      void'($urandom(32'h5EED));
      reset        = 1'b0;
      shift_string = '0;
      shift_amount = '0;
      left         = 1'b0;
      test_reset();
      test_directed();
      test_hold_between_edges();
      test_back_to_back();
      test_sweep();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
